// File: rtl/stream_credit_tx.sv
// Credit-flow link transmitter: forwards source words as registered link beats and
// never sends more beats than the remote FIFO has room for. Optional err_o via STREAM_CREDIT_TX_ERR_EN.
module stream_credit_tx #(
  parameter int CreditNum = 8,
  parameter int WordWidth = 64,
  localparam int CntW = $clog2(CreditNum + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_vld_i,
  input  logic [WordWidth-1:0] src_payload_i,
  output logic                 src_rdy_o,
  output logic                 link_vld_o,
  output logic [WordWidth-1:0] link_payload_o,
  input  logic                 link_credit_i,
  input  logic                 flush_i,
  output logic [CntW-1:0]      credit_cnt_o,
  output logic                 idle_o
`ifdef STREAM_CREDIT_TX_ERR_EN
  ,
  output logic                 err_o
`endif
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [CntW-1:0] CntMax = CntW'(CreditNum);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [CntW-1:0]      cnt_r;
  logic [CntW-1:0]      cnt_nxt_s;
  logic                 src_rdy_r;
  logic                 link_vld_r;
  logic [WordWidth-1:0] link_payload_r;
  logic                 idle_r;
  logic                 fire_s;

  // Ready is registered; flush only masks it so no word is taken while both ends are cleared.
  assign src_rdy_o      = src_rdy_r & ~flush_i;
  assign fire_s         = src_vld_i & src_rdy_o;
  assign link_vld_o     = link_vld_r;
  assign link_payload_o = link_payload_r;
  assign credit_cnt_o   = cnt_r;
  assign idle_o         = idle_r;

  // Next credit count and FSM state; the count saturates at CreditNum on over-return.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    if (flush_i) begin
      cnt_nxt_s   = CntMax;
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_nxt_s   = CntMax;
          state_nxt_s = ST_RUN;
        end
        ST_RUN, ST_STALL: begin
          if (fire_s && !link_credit_i) begin
            cnt_nxt_s = cnt_r - CntW'(1);
          end else if (!fire_s && link_credit_i && (cnt_r != CntMax)) begin
            cnt_nxt_s = cnt_r + CntW'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
          state_nxt_s = (cnt_nxt_s == CntW'(0)) ? ST_STALL : ST_RUN;
        end
        default: begin
          cnt_nxt_s   = CntMax;
          state_nxt_s = ST_INIT;
        end
      endcase
    end
  end

  // State, credit count, link register and derived status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_INIT;
      cnt_r          <= CntMax;
      src_rdy_r      <= 1'b0;
      link_vld_r     <= 1'b0;
      link_payload_r <= {WordWidth{1'b0}};
      idle_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      src_rdy_r      <= (state_nxt_s == ST_RUN);
      link_vld_r     <= fire_s;
      link_payload_r <= fire_s ? src_payload_i : link_payload_r;
      idle_r         <= (cnt_nxt_s == CntMax) & ~fire_s & (state_nxt_s != ST_INIT);
    end
  end

`ifdef STREAM_CREDIT_TX_ERR_EN
  logic err_r;
  assign err_o = err_r;

  // Sticky over-return flag; INIT holds the count at CreditNum so early credits also trip it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (flush_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (link_credit_i & ~fire_s & (cnt_r == CntMax));
    end
  end
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Scoreboard bench for stream_credit_tx: directed steps push expected beats, a monitor
// pops and compares payload and arrival cycle whenever a link beat is presented.
module tb_stream_credit_tx;

  localparam int CN = 8;
  localparam int WW = 64;
  localparam int CW = $clog2(CN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_vld_i = 1'b0;
  logic [WW-1:0] src_payload_i = '0;
  logic          src_rdy_o;
  logic          link_vld_o;
  logic [WW-1:0] link_payload_o;
  logic          link_credit_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [CW-1:0] credit_cnt_o;
  logic          idle_o;
`ifdef STREAM_CREDIT_TX_ERR_EN
  logic          err_o;
`endif

  stream_credit_tx #(.CreditNum(CN), .WordWidth(WW)) dut (
    .clk(clk), .rst(rst),
    .src_vld_i(src_vld_i), .src_payload_i(src_payload_i), .src_rdy_o(src_rdy_o),
    .link_vld_o(link_vld_o), .link_payload_o(link_payload_o),
    .link_credit_i(link_credit_i), .flush_i(flush_i),
    .credit_cnt_o(credit_cnt_o), .idle_o(idle_o)
`ifdef STREAM_CREDIT_TX_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pay;
    int          cyc;
  } beat_t;

  beat_t sb_q[$];
  int    cyc = 0;
  int    total = 0;
  int    passed = 0;
  logic  prev_fire = 1'b0;
  logic  exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus; expectations describe the outputs seen during this cycle.
  task automatic step(input logic vld, input logic [63:0] pay, input logic cr, input logic fl,
                      input logic e_rdy, input int e_cnt, input logic e_idle);
    beat_t b;
    @(posedge clk);
    #1;
    src_vld_i     = vld;
    src_payload_i = pay;
    link_credit_i = cr;
    flush_i       = fl;
    if (vld && e_rdy && !fl) begin
      b.pay = pay;
      b.cyc = cyc + 1;
      sb_q.push_back(b);
    end
    @(negedge clk);
    check("src_rdy", {63'd0, src_rdy_o}, {63'd0, e_rdy});
    check("credit_cnt", 64'(credit_cnt_o), 64'(e_cnt));
    check("idle", {63'd0, idle_o}, {63'd0, e_idle});
    check("link_vld", {63'd0, link_vld_o}, {63'd0, prev_fire});
`ifdef STREAM_CREDIT_TX_ERR_EN
    check("err", {63'd0, err_o}, {63'd0, exp_err});
`endif
    prev_fire = vld & e_rdy & ~fl;
  endtask

  // Monitor: every presented beat must match the oldest expected beat and its cycle.
  always @(negedge clk) begin
    if (!rst && link_vld_o) begin
      if (sb_q.size() == 0) begin
        check("beat_unexpected", 64'd1, 64'd0);
      end else begin
        beat_t b;
        b = sb_q.pop_front();
        check("beat_payload", link_payload_o, b.pay);
        check("beat_cycle", 64'(cyc), 64'(b.cyc));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("init_rdy", {63'd0, src_rdy_o}, 64'd0);
    check("init_cnt", 64'(credit_cnt_o), 64'(CN));
    check("init_idle", {63'd0, idle_o}, 64'd0);
    check("init_vld", {63'd0, link_vld_o}, 64'd0);

    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    for (int k = 1; k <= 8; k++)
      step(1'b1, 64'(k), 1'b0, 1'b0, 1'b1, 9 - k, (k == 1));
    step(1'b1, 64'h9, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 64'h9, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 64'h9, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 3; k++)
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, k, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 64'hA0 + 64'(i), 1'b1, 1'b0, 1'b1, 4, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 4, 1'b0);

    step(1'b1, 64'hB0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    step(1'b1, 64'hB1, 1'b1, 1'b1, 1'b0, 3, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);

    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    exp_err = 1'b1;
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 8, 1'b1);
    exp_err = 1'b0;
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);

    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_payload", link_payload_o, 64'h0);
    check("rst_vld", {63'd0, link_vld_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    flush_i = 1'b1;
    prev_fire = 1'b0;
    @(negedge clk);
    check("init_flush_rdy", {63'd0, src_rdy_o}, 64'd0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 8, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_credit_tx.md
Name: stream_credit_tx

Overview:
- Transmit end of a credit-flow link whose receive end is a stream FIFO of known depth at the far side of a NoC hop.
- Accepts words from a local valid/ready source and forwards them as a registered valid-only link beat.
- Spends one credit per beat and regains one credit per returned pulse, so the remote FIFO can never overflow.
- Sits between a router/arbiter output and the physical link wires.

Parameters:
CreditNum, 8, remote receive FIFO depth (initial and maximum credit count), >=1
WordWidth, 64, payload width in bits

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; asynchronous, active-high
src_vld_i  input  1  local source word valid
src_payload_i  input  WordWidth  local source word
src_rdy_o  output  1  block accepts the source word this cycle
link_vld_o  output  1  link beat valid (registered, no ready)
link_payload_o  output  WordWidth  link beat payload (registered)
link_credit_i  input  1  one-cycle pulse, one credit returned by the receiver
flush_i  input  1  synchronous flush, asserted to both link ends in the same cycle
credit_cnt_o  output  $clog2(CreditNum+1)  current available credits
idle_o  output  1  all credits home and no beat in flight on the output register

Behaviour:
- Reset (async assert): FSM=INIT, credit count=CreditNum, link_vld_o=0, link_payload_o=0, src_rdy_o=0, idle_o=0.
- Reset deassertion is taken synchronously.
- FSM:
  - INIT: lasts exactly 1 cycle after reset release, then RUN. src_rdy_o=0 in INIT.
  - RUN: credit count >0. src_rdy_o=1.
  - STALL: credit count ==0. src_rdy_o=0.
  - RUN->STALL when the count reaches 0 at the edge. STALL->RUN when a credit returns.
- Fire: src_fire = src_vld_i & src_rdy_o.
  - On src_fire, the next cycle has link_vld_o=1 and link_payload_o=src_payload_i (latency 1).
  - Without src_fire, link_vld_o=0 and link_payload_o holds its last value.
  - Back-to-back fires give back-to-back beats at 1 word/cycle.
- Counter update:
  - next = cnt - src_fire + link_credit_i.
  - Simultaneous fire and credit return: count unchanged, state unchanged.
- Credit return while in STALL with src_vld_i high: src_rdy_o rises in the following cycle, never combinationally from link_credit_i.
- src_rdy_o depends only on registered state; there is no combinational path from src_vld_i or link_credit_i.
- Over-return: link_credit_i while cnt==CreditNum and no fire is a protocol violation.
  - The count saturates at CreditNum; it never wraps.
- flush_i:
  - Next cycle: count=CreditNum, link_vld_o=0, FSM=RUN.
  - src_rdy_o=0 during the flush cycle; any src_vld_i in that cycle is not accepted.
  - link_credit_i is ignored in the flush cycle.
  - flush_i in INIT: go to RUN with count=CreditNum.
- idle_o = (cnt==CreditNum) & ~link_vld_o & (FSM!=INIT).
- credit_cnt_o reflects the registered count.

Optional Feature:
- Macro: STREAM_CREDIT_TX_ERR_EN.
- When defined: adds output port err_o (1 bit), reset 0.
  - Sticky; set on an over-return (link_credit_i while cnt==CreditNum and no fire in that cycle).
  - Cleared only by rst or flush_i.
  - Also sets on any link_credit_i observed during INIT.
- When undefined: no err_o port and no error logic; saturation behaviour is unchanged.

Test Plan:
- Reset then idle, CreditNum=8 -> cycle 0 after release src_rdy_o=0; cycle 1 src_rdy_o=1, credit_cnt_o=8, idle_o=1.
- Drive 8 consecutive words 0x1..0x8, no credits returned -> link beats 0x1..0x8 one cycle after each accept; credit_cnt_o 8->0; src_rdy_o=0 from the cycle after the 8th accept; 9th word held.
- In STALL, pulse link_credit_i once -> next cycle src_rdy_o=1 and 9th word accepted; its beat appears one cycle later; count returns to 0.
- Continuous src_vld_i with link_credit_i every cycle at count=4 -> count stays 4; beats every cycle; no STALL entry.
- Mid-stream flush at count=3 with link_vld_o=1 -> next cycle count=8, link_vld_o=0, idle_o=1; source word presented in the flush cycle is not accepted.
- With STREAM_CREDIT_TX_ERR_EN: link_credit_i at count=8 -> count stays 8, err_o=1 and remains 1 until flush_i, after which err_o=0.
